pcm_sdm_dac: RTL and testbench

- Parametrised multi-channel PCM-to-1-bit sigma-delta DAC core. Successor to the fixed 2-channel, 16-bit, flash-coupled player.
- Accepts PCM frames over a valid/ready stream into a frame FIFO and pops one frame per sample tick.
- Runs one first-order sigma-delta modulator per channel at an oversampling rate derived from CLK_48.
- Sits between any frame source (SPI flash reader, USB, test generator) and the audio output pins. Single clock domain, no derived clocks.

---
 rtl/pcm_sdm_dac.sv | 189 ++++++++++++++++++
 tb/tb_pcm_sdm_dac.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pcm_sdm_dac.sv
// Multi-channel PCM frame FIFO feeding one 1-bit sigma-delta modulator per channel.
// Define PCM_SDM_ORDER2_EN to build second-order error-feedback modulators instead of first order.
module pcm_sdm_dac #(
  parameter int CHANNELS   = 2,
  parameter int BITS       = 16,
  parameter int SIGNED     = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int FS_DIV     = 1000,
  parameter int MOD_DIV    = 1
) (
  input  logic                         CLK_48,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*BITS-1:0]     s_data,
  input  logic                         underrun_clr,
  output logic [CHANNELS-1:0]          dac_out,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         underrun,
  output logic [15:0]                  underrun_cnt,
  output logic                         sample_tick
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int FW    = $clog2(FS_DIV);
  localparam int MW    = $clog2(MOD_DIV + 1);
  localparam int FBITS = CHANNELS * BITS;
  localparam logic [BITS-1:0] MID  = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] FLIP = (SIGNED != 0) ? MID : '0;

  // Stream handshake: a frame transfers on any CLK_48 edge where s_valid && s_ready.
  // s_ready decodes only the registered level, so a pop in the same cycle never frees a slot early.
  logic [FBITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [FW-1:0]    r_fs_cnt;
  logic [MW-1:0]    r_mod_cnt;
  logic             r_sample_tick;
  logic             r_underrun;
  logic [15:0]      r_underrun_cnt;
  logic [BITS-1:0]  r_hold [CHANNELS];
  logic [CHANNELS-1:0] r_dac;

  logic             w_push;
  logic             w_pop;
  logic             w_fs_wrap;
  logic             w_mod_en;
  logic             w_empty;
  logic [FBITS-1:0] w_head;

  assign s_ready      = (r_level != LW'(FIFO_DEPTH));
  assign w_push       = s_valid && s_ready;
  assign w_empty      = (r_level == '0);
  assign w_fs_wrap    = enable && (r_fs_cnt == FW'(FS_DIV - 1));
  assign w_pop        = w_fs_wrap && !w_empty;
  assign w_mod_en     = enable && (r_mod_cnt == MW'(MOD_DIV - 1));
  assign w_head       = r_mem[r_rd_ptr];

  assign fifo_level   = r_level;
  assign sample_tick  = r_sample_tick;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;
  assign dac_out      = r_dac;

  always_ff @(posedge CLK_48) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge CLK_48) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge CLK_48) begin
    if (!resetn) begin
      r_fs_cnt      <= '0;
      r_sample_tick <= 1'b0;
    end else begin
      r_sample_tick <= w_fs_wrap;
      if (w_fs_wrap)   r_fs_cnt <= '0;
      else if (enable) r_fs_cnt <= r_fs_cnt + FW'(1);
    end
  end

  always_ff @(posedge CLK_48) begin
    if (!resetn) begin
      r_mod_cnt <= '0;
    end else if (enable) begin
      r_mod_cnt <= w_mod_en ? '0 : r_mod_cnt + MW'(1);
    end
  end

  // An empty FIFO at a tick plays silence rather than repeating the last sample.
  always_ff @(posedge CLK_48) begin
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) r_hold[c] <= MID;
    end else if (w_fs_wrap) begin
      for (int c = 0; c < CHANNELS; c++)
        r_hold[c] <= w_pop ? (w_head[c*BITS +: BITS] ^ FLIP) : MID;
    end
  end

  always_ff @(posedge CLK_48) begin
    if (!resetn) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else if (w_fs_wrap && w_empty) begin
      r_underrun     <= 1'b1;
      if (underrun_clr)                   r_underrun_cnt <= 16'd1;
      else if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end else if (underrun_clr) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end
  end

`ifdef PCM_SDM_ORDER2_EN
  localparam int IW = BITS + 3;
  localparam logic [IW-1:0] FB_POS = IW'(MID);
  localparam logic [IW-1:0] FB_NEG = ~FB_POS + IW'(1);

  logic [IW-1:0] r_int1 [CHANNELS];
  logic [IW-1:0] r_int2 [CHANNELS];
  logic [IW-1:0] w_int1_next [CHANNELS];
  logic [IW-1:0] w_int2_next [CHANNELS];

  // Input is re-centred around midscale; feedback follows the current sign of integrator 2.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_int1_next[c] = r_int1[c] + (IW'(r_hold[c]) - FB_POS)
                       - (r_int2[c][IW-1] ? FB_NEG : FB_POS);
      w_int2_next[c] = r_int2[c] + w_int1_next[c]
                       - (r_int2[c][IW-1] ? FB_NEG : FB_POS);
    end
  end

  always_ff @(posedge CLK_48) begin
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_int1[c] <= '0;
        r_int2[c] <= '0;
      end
      r_dac <= '0;
    end else if (!enable) begin
      r_dac <= '0;
    end else if (w_mod_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_int1[c] <= w_int1_next[c];
        r_int2[c] <= w_int2_next[c];
        r_dac[c]  <= ~w_int2_next[c][IW-1];
      end
    end
  end
`else
  logic [BITS:0] r_acc [CHANNELS];
  logic [BITS:0] w_acc_next [CHANNELS];

  // The carry out of the low BITS bits is the output pulse; it is dropped before the next add.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      w_acc_next[c] = {1'b0, r_acc[c][BITS-1:0]} + {1'b0, r_hold[c]};
  end

  always_ff @(posedge CLK_48) begin
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
      r_dac <= '0;
    end else if (!enable) begin
      r_dac <= '0;
    end else if (w_mod_en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= w_acc_next[c];
        r_dac[c] <= w_acc_next[c][BITS];
      end
    end
  end
`endif

endmodule

// File: tb/tb_pcm_sdm_dac.sv
// Directed bench for pcm_sdm_dac: reset, underrun, freeze, FIFO order/full, duty cycle.
// Build with PCM_SDM_ORDER2_EN defined to exercise the second-order duty check.
module tb_pcm_sdm_dac;

  localparam int CH    = 2;
  localparam int BITS  = 16;
  localparam int DEPTH = 16;
  localparam int FSD   = 64;

  logic        CLK_48 = 1'b0;
  logic        resetn;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        underrun_clr;
  logic [1:0]  dac_out;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic        sample_tick;

  int n_checks = 0;
  int n_errors = 0;
  int n_en     = 0;

  pcm_sdm_dac #(
    .CHANNELS(CH), .BITS(BITS), .SIGNED(1), .FIFO_DEPTH(DEPTH), .FS_DIV(FSD), .MOD_DIV(1)
  ) dut (
    .CLK_48(CLK_48), .resetn(resetn), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .underrun_clr(underrun_clr), .dac_out(dac_out), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .sample_tick(sample_tick)
  );

  always #5 CLK_48 = ~CLK_48;

  // Number of modulator updates since reset (MOD_DIV = 1: every enabled edge).
  always @(posedge CLK_48) begin
    if (!resetn)     n_en <= 0;
    else if (enable) n_en <= n_en + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK_48);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_tick(input string tag, output int k);
    k = 0;
    do begin
      step(1);
      k++;
    end while (sample_tick !== 1'b1 && k < 200);
    chk(tag, {31'd0, sample_tick}, 32'd1);
  endtask

  // Accumulator with constant midscale hold: 0, 0x08000, 0x10000, 0x08000, ...
  function automatic logic [31:0] exp_acc(input int n);
    if (n == 0)      return 32'h0;
    else if (n % 2)  return 32'h08000;
    else             return 32'h10000;
  endfunction

  initial begin
    int k;
    int ones0;
    int ones1;

    resetn = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; underrun_clr = 1'b0;
    step(3);
    chk("rst_dac",     {30'd0, dac_out}, 32'd0);
    chk("rst_ready",   {31'd0, s_ready}, 32'd1);
    chk("rst_level",   {27'd0, fifo_level}, 32'd0);
    chk("rst_underrun",{31'd0, underrun}, 32'd0);
    chk("rst_cnt",     {16'd0, underrun_cnt}, 32'd0);
    chk("rst_tick",    {31'd0, sample_tick}, 32'd0);
    chk("rst_hold0",   {16'd0, dut.r_hold[0]}, 32'h8000);

    // Empty FIFO: three underrun ticks
    resetn = 1'b1; enable = 1'b1;
    for (int t = 0; t < 3; t++) wait_tick("ur_tick", k);
    chk("ur_flag",  {31'd0, underrun}, 32'd1);
    chk("ur_cnt",   {16'd0, underrun_cnt}, 32'd3);
    chk("ur_hold0", {16'd0, dut.r_hold[0]}, 32'h8000);
    chk("ur_hold1", {16'd0, dut.r_hold[1]}, 32'h8000);
    step(1);
    chk("tick_pulse_width", {31'd0, sample_tick}, 32'd0);
    underrun_clr = 1'b1; step(1); underrun_clr = 1'b0;
    chk("ur_clr_flag", {31'd0, underrun}, 32'd0);
    chk("ur_clr_cnt",  {16'd0, underrun_cnt}, 32'd0);
    // Clear lands on the cycle of the next underrun tick
    step(61);
    underrun_clr = 1'b1; step(1); underrun_clr = 1'b0;
    chk("coinc_tick", {31'd0, sample_tick}, 32'd1);
    chk("coinc_flag", {31'd0, underrun}, 32'd1);
    chk("coinc_cnt",  {16'd0, underrun_cnt}, 32'd1);

    // Freeze with 4 frames queued; fs counter is 0 here
    enable = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hFEDC_1234; step(1);
    s_data = 32'h0001_8000; step(1);
    s_data = 32'h1111_2222; step(1);
    s_data = 32'h3333_4444; step(1);
    s_valid = 1'b0;
    step(496);
    chk("frz_level", {27'd0, fifo_level}, 32'd4);
    chk("frz_dac",   {30'd0, dac_out}, 32'd0);
    chk("frz_cnt",   {16'd0, underrun_cnt}, 32'd1);
    chk("frz_hold0", {16'd0, dut.r_hold[0]}, 32'h8000);
`ifndef PCM_SDM_ORDER2_EN
    chk("frz_acc0", {15'd0, dut.r_acc[0]}, exp_acc(n_en));
    chk("frz_acc1", {15'd0, dut.r_acc[1]}, exp_acc(n_en));
`endif

    enable = 1'b1;
    wait_tick("reen_tick", k);
    chk("reen_latency", k, 32'd64);
    chk("pop1_level",   {27'd0, fifo_level}, 32'd3);
    chk("pop1_hold0",   {16'd0, dut.r_hold[0]}, 32'h9234);
    chk("pop1_hold1",   {16'd0, dut.r_hold[1]}, 32'h7EDC);
    wait_tick("pop2_tick", k);
    chk("pop2_latency", k, 32'd64);
    chk("pop2_level",   {27'd0, fifo_level}, 32'd2);
    chk("pop2_hold0",   {16'd0, dut.r_hold[0]}, 32'h0000);
    chk("pop2_hold1",   {16'd0, dut.r_hold[1]}, 32'h8001);

    // Mid-run reset with level 5
    enable = 1'b0;
    s_valid = 1'b1; s_data = 32'h1111_2222; step(3); s_valid = 1'b0;
    chk("mid_level", {27'd0, fifo_level}, 32'd5);
    resetn = 1'b0; step(1);
    chk("mid_rst_level", {27'd0, fifo_level}, 32'd0);
    chk("mid_rst_ready", {31'd0, s_ready}, 32'd1);
    resetn = 1'b1;

    // 17 back-to-back pushes with no ticks
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1;
      s_data  = {16'(i), 16'(i + 100)};
      chk("full_ready", {31'd0, s_ready}, (i < 16) ? 32'd1 : 32'd0);
      step(1);
    end
    chk("full_level", {27'd0, fifo_level}, 32'd16);
    chk("full_ready_after", {31'd0, s_ready}, 32'd0);
    enable = 1'b1; s_data = 32'hAAAA_5555;
    wait_tick("full_tick", k);
    chk("full_pop_level", {27'd0, fifo_level}, 32'd15);
    chk("full_pop_ready", {31'd0, s_ready}, 32'd1);
    step(1);
    chk("full_refill_level", {27'd0, fifo_level}, 32'd16);
    chk("full_refill_ready", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b0; enable = 1'b0;

    // Duty cycle with a continuously refilled FIFO
    resetn = 1'b0; step(2); resetn = 1'b1;
    enable = 1'b1; s_valid = 1'b1;
`ifdef PCM_SDM_ORDER2_EN
    s_data = 32'h0000_4000;
`else
    s_data = 32'h7FFF_0000;
`endif
    wait_tick("duty_tick", k);
`ifdef PCM_SDM_ORDER2_EN
    chk("duty_hold0", {16'd0, dut.r_hold[0]}, 32'hC000);
`else
    chk("duty_hold1", {16'd0, dut.r_hold[1]}, 32'hFFFF);
`endif
    ones0 = 0; ones1 = 0;
    for (int j = 0; j < 65536; j++) begin
      step(1);
      ones0 += int'(dac_out[0]);
      ones1 += int'(dac_out[1]);
    end
`ifdef PCM_SDM_ORDER2_EN
    chk_range("duty_ch0", ones0, 49148, 49156);
    chk_range("duty_ch1", ones1, 32764, 32772);
`else
    chk_range("duty_ch0", ones0, 32767, 32769);
    chk_range("duty_ch1", ones1, 65534, 65536);
`endif
    chk("duty_no_underrun", {31'd0, underrun}, 32'd0);
    s_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
